// File: rtl/mod_dmem_port.sv
// Data-memory responder: turns one 64-bit load or store into 64-byte line transactions
// on the system bus. Stores read the line, merge the word and write the whole line back.
module mod_dmem_port #(
    parameter int               DATA_W     = 64,
    parameter int               LINE_BEATS = 8,
    parameter int               TAG_W      = 13,
    parameter logic [TAG_W-2:0] REQ_ID     = 12'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] load_buffer,
    output logic              load_done,
    output logic              store_done,
    output logic              busy,
    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    input  logic [TAG_W-1:0]  bus_resptag,
    output logic              bus_respack
);

    localparam int BEAT_W   = $clog2(LINE_BEATS);
    localparam int WORD_LSB = $clog2(DATA_W / 8);
    localparam int LINE_LSB = WORD_LSB + BEAT_W;

    localparam logic [TAG_W-1:0]  RD_TAG    = {1'b0, REQ_ID};
    localparam logic [TAG_W-1:0]  WR_TAG    = {1'b1, REQ_ID};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        WR_DATA,
        DONE
    } state_t;

    state_t state, next_state;

    logic [BEAT_W-1:0] beat;
    logic              op_store;
    logic [63:WORD_LSB] addr_q;
    logic [DATA_W-1:0] st_data_q;
    logic [DATA_W-1:0] line [LINE_BEATS];

    logic [63:0]       line_base;
    logic [BEAT_W-1:0] word_idx;
    logic              last_beat;
    logic              rd_hit;
    logic              rd_accept;
    logic              wr_accept;
    logic              start;
    logic [DATA_W-1:0] rd_word;

    // Byte-offset bits inside a word carry no information for an aligned access.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[WORD_LSB-1:0];

    assign line_base = {addr_q[63:LINE_LSB], {LINE_LSB{1'b0}}};
    assign word_idx  = addr_q[LINE_LSB-1:WORD_LSB];
    assign last_beat = (beat == LAST_BEAT);
    assign rd_hit    = bus_respcyc && (bus_resptag == RD_TAG);
    assign start     = ld_req || st_req;
    assign busy      = (state != IDLE);

    // The requested word may arrive on the very beat that completes the line.
    assign rd_word = (word_idx == beat) ? bus_resp : line[word_idx];

    always_comb begin
        next_state  = state;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        rd_accept   = 1'b0;
        wr_accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RD_REQ;
            end
            RD_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = DATA_W'(line_base);
                bus_reqtag = RD_TAG;
                if (bus_reqack) next_state = RD_DATA;
            end
            RD_DATA: begin
                bus_respack = rd_hit;
                rd_accept   = rd_hit;
                if (rd_hit && last_beat) next_state = op_store ? WR_REQ : DONE;
            end
            WR_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = DATA_W'(line_base);
                bus_reqtag = WR_TAG;
                if (bus_reqack) next_state = WR_DATA;
            end
            WR_DATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = line[beat];
                bus_reqtag = WR_TAG;
                wr_accept  = bus_reqack;
                if (bus_reqack && last_beat) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat        <= '0;
            op_store    <= 1'b0;
            load_buffer <= '0;
            load_done   <= 1'b0;
            store_done  <= 1'b0;
        end else begin
            state      <= next_state;
            load_done  <= 1'b0;
            store_done <= 1'b0;
            case (state)
                IDLE: begin
                    beat <= '0;
                    // A simultaneous load wins; the store request stays pending.
                    if (ld_req) op_store <= 1'b0;
                    else if (st_req) op_store <= 1'b1;
                end
                RD_DATA: begin
                    if (rd_accept) begin
                        beat <= last_beat ? '0 : beat + BEAT_W'(1);
                        if (last_beat && !op_store) begin
                            load_buffer <= rd_word;
                            load_done   <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_accept) begin
                        beat <= last_beat ? '0 : beat + BEAT_W'(1);
                        if (last_beat) store_done <= 1'b1;
                    end
                end
                default: begin
                    beat <= '0;
                end
            endcase
        end
    end

    // Store word is merged as its beat arrives, so the write-back sees the final line.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            addr_q    <= req_addr[63:WORD_LSB];
            st_data_q <= st_data;
        end
        if (rd_accept) begin
            line[beat] <= (op_store && beat == word_idx) ? st_data_q : bus_resp;
        end
    end

endmodule

// File: tb/tb_mod_dmem_port.sv
// Bench for mod_dmem_port: scripted and randomized load/store transactions against a
// line-level reference model of the expected bus traffic and results.
module tb_mod_dmem_port;

    localparam int TAG_W = 13;
    localparam logic [TAG_W-1:0] RD_TAG = 13'h0001;
    localparam logic [TAG_W-1:0] WR_TAG = 13'h1001;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req, st_req;
    logic [63:0] req_addr, st_data;
    logic [63:0] load_buffer;
    logic        load_done, store_done, busy;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [TAG_W-1:0] bus_reqtag;
    logic        bus_reqack, bus_respcyc;
    logic [63:0] bus_resp;
    logic [TAG_W-1:0] bus_resptag;
    logic        bus_respack;

    int checks = 0;
    int failures = 0;
    int ld_pulses = 0;
    int st_pulses = 0;

    logic [63:0] line_data [8];
    logic [63:0] model_lbuf;

    logic        o_timeout, o_done_now, o_done_after, o_busy_after, o_abort_err;
    logic [63:0] o_rd_addr, o_wr_addr, o_lbuf;
    logic [TAG_W-1:0] o_rd_tag, o_wr_tag;
    int          o_stall_err, o_ack_err, o_wr_tag_err;
    logic [63:0] o_wr_beats [8];

    mod_dmem_port dut (
        .clk         (clk),
        .reset       (reset),
        .ld_req      (ld_req),
        .st_req      (st_req),
        .req_addr    (req_addr),
        .st_data     (st_data),
        .load_buffer (load_buffer),
        .load_done   (load_done),
        .store_done  (store_done),
        .busy        (busy),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done === 1'b1) ld_pulses++;
        if (store_done === 1'b1) st_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: line address, loaded word and written-back line.
    function automatic logic [63:0] exp_base(input logic [63:0] a);
        return a & ~64'h3F;
    endfunction

    function automatic logic [63:0] exp_word(input logic [63:0] a);
        return line_data[a[5:3]];
    endfunction

    function automatic logic [63:0] exp_wr(input logic [63:0] a, input logic [63:0] d, input int k);
        return (k == int'(a[5:3])) ? d : line_data[k];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        req_addr = '0; st_data = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        model_lbuf = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_line();
        for (int k = 0; k < 8; k++) line_data[k] = rnd64();
    endtask

    // Plays the bus side of one transaction and records what the DUT did.
    task automatic bus_txn(input bit is_store, input int ack_delay, input int foreign_at,
                           input int gap_max, input int abort_at,
                           input logic [63:0] next_addr, input logic [63:0] next_data);
        int t;
        o_timeout = 0; o_stall_err = 0; o_ack_err = 0; o_wr_tag_err = 0; o_abort_err = 0;
        o_done_now = 0; o_done_after = 0; o_busy_after = 1;
        t = 0;
        while (!(bus_reqcyc === 1'b1 && bus_reqtag[TAG_W-1] === 1'b0)) begin
            @(negedge clk); t++;
            if (t > 100) begin o_timeout = 1; return; end
        end
        o_rd_addr = bus_req; o_rd_tag = bus_reqtag;
        req_addr = rnd64(); st_data = rnd64();
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            if (bus_reqcyc !== 1'b1 || bus_req !== o_rd_addr || bus_reqtag !== o_rd_tag || busy !== 1'b1)
                o_stall_err++;
        end
        bus_reqack = 1'b1; @(negedge clk); bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
                bus_respcyc = 1'b0; #1;
                if (bus_respack !== 1'b0) o_ack_err++;
                @(negedge clk);
            end
            if (k == foreign_at) begin
                bus_respcyc = 1'b1; bus_resp = rnd64();
                bus_resptag = ($urandom_range(0, 1) == 0) ? 13'h0005 : WR_TAG;
                #1;
                if (bus_respack !== 1'b0) o_ack_err++;
                @(negedge clk);
            end
            bus_respcyc = 1'b1; bus_resptag = RD_TAG; bus_resp = line_data[k];
            #1;
            if (bus_respack !== 1'b1) o_ack_err++;
            @(negedge clk);
        end
        bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        if (is_store) begin
            t = 0;
            while (!(bus_reqcyc === 1'b1 && bus_reqtag[TAG_W-1] === 1'b1)) begin
                @(negedge clk); t++;
                if (t > 50) begin o_timeout = 1; return; end
            end
            o_wr_addr = bus_req; o_wr_tag = bus_reqtag;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus_reqack = 1'b1; @(negedge clk); bus_reqack = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                if (k == abort_at) begin
                    reset = 1'b0; #1;
                    if ({busy, bus_reqcyc, bus_respack, load_done, store_done} !== 5'b0 ||
                        bus_req !== 64'h0 || bus_reqtag !== '0 || load_buffer !== 64'h0)
                        o_abort_err = 1;
                    st_req = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
                o_wr_beats[k] = bus_req;
                if (bus_reqtag !== WR_TAG || bus_reqcyc !== 1'b1) o_wr_tag_err++;
                bus_reqack = 1'b1; @(negedge clk); bus_reqack = 1'b0;
            end
            o_done_now = store_done; st_req = 1'b0;
        end else begin
            o_done_now = load_done; ld_req = 1'b0;
        end
        o_lbuf = load_buffer;
        req_addr = next_addr; st_data = next_data;
        @(negedge clk);
        o_busy_after = busy;
        o_done_after = load_done | store_done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; ld_req = 1'b1; st_req = 1'b1; req_addr = 64'h40; st_data = 64'h1;
        bus_reqack = 1'b1; bus_respcyc = 1'b1; bus_resp = 64'h5; bus_resptag = RD_TAG;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, bus_reqcyc, bus_respack, load_done, store_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, bus_reqcyc, bus_respack, load_done, store_done});
        end
        checks++;
        if (bus_req !== 64'h0 || bus_reqtag !== 13'h0 || load_buffer !== 64'h0) begin
            failures++;
            $display("FAIL reset_data bus_req=%h tag=%h load_buffer=%h exp all 0", bus_req, bus_reqtag, load_buffer);
        end
        do_reset();
    endtask

    task automatic test_load_basic();
        int b;
        do_reset();
        for (int k = 0; k < 8; k++) line_data[k] = 64'(k) * 64'h1111;
        b = ld_pulses;
        ld_req = 1'b1; req_addr = 64'h1018;
        bus_txn(0, 0, -1, 0, -1, 64'h0, 64'h0);
        #1;
        checks++;
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL load_timeout got=%b exp=0", o_timeout); end
        checks++;
        if (o_rd_addr !== 64'h1000 || o_rd_tag !== RD_TAG) begin
            failures++; $display("FAIL load_rdreq addr=%h tag=%h exp 1000/%h", o_rd_addr, o_rd_tag, RD_TAG);
        end
        checks++;
        if (o_done_now !== 1'b1 || o_lbuf !== 64'h3333) begin
            failures++; $display("FAIL load_result done=%b data=%h exp 1/3333", o_done_now, o_lbuf);
        end
        checks++;
        if (o_ack_err != 0) begin failures++; $display("FAIL load_respack errors got=%0d exp=0", o_ack_err); end
        checks++;
        if (ld_pulses - b != 1 || o_done_after !== 1'b0 || o_busy_after !== 1'b0) begin
            failures++;
            $display("FAIL load_pulse count=%0d after=%b busy=%b exp 1/0/0", ld_pulses - b, o_done_after, o_busy_after);
        end
        model_lbuf = 64'h3333;
    endtask

    task automatic test_store_basic();
        int b, bad;
        do_reset();
        rand_line();
        b = st_pulses;
        st_req = 1'b1; req_addr = 64'h2008; st_data = 64'hDEADBEEF;
        bus_txn(1, 1, -1, 1, -1, 64'h0, 64'h0);
        #1;
        checks++;
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL store_timeout got=%b exp=0", o_timeout); end
        checks++;
        if (o_rd_addr !== 64'h2000 || o_wr_addr !== 64'h2000 || o_wr_tag !== WR_TAG || o_wr_tag_err != 0) begin
            failures++;
            $display("FAIL store_req rd=%h wr=%h tag=%h tagerr=%0d exp 2000/2000/%h/0", o_rd_addr, o_wr_addr, o_wr_tag, o_wr_tag_err, WR_TAG);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_wr_beats[k] !== ((k == 1) ? 64'hDEADBEEF : line_data[k])) begin
                failures++;
                $display("FAIL store_beat%0d got=%h exp=%h", k, o_wr_beats[k], (k == 1) ? 64'hDEADBEEF : line_data[k]);
            end
        end
        bad = (st_pulses - b != 1) || (o_done_now !== 1'b1) || (o_done_after !== 1'b0);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL store_pulse count=%0d now=%b after=%b exp 1/1/0", st_pulses - b, o_done_now, o_done_after);
        end
    endtask

    task automatic test_reqack_stall();
        logic [63:0] a;
        do_reset();
        rand_line();
        a = rnd64();
        ld_req = 1'b1; req_addr = a;
        bus_txn(0, 5, -1, 0, -1, 64'h0, 64'h0);
        checks++;
        if (o_stall_err != 0 || o_timeout !== 1'b0) begin
            failures++; $display("FAIL stall_hold errors=%0d timeout=%b exp 0/0", o_stall_err, o_timeout);
        end
        checks++;
        if (o_rd_addr !== exp_base(a) || o_lbuf !== exp_word(a) || o_done_now !== 1'b1) begin
            failures++;
            $display("FAIL stall_result addr=%h data=%h done=%b exp %h/%h/1", o_rd_addr, o_lbuf, o_done_now, exp_base(a), exp_word(a));
        end
        model_lbuf = exp_word(a);
    endtask

    task automatic test_foreign_tag();
        logic [63:0] a;
        do_reset();
        rand_line();
        a = rnd64();
        ld_req = 1'b1; req_addr = a;
        bus_txn(0, 0, 3, 1, -1, 64'h0, 64'h0);
        checks++;
        if (o_ack_err != 0) begin failures++; $display("FAIL foreign_respack errors got=%0d exp=0", o_ack_err); end
        checks++;
        if (o_lbuf !== exp_word(a) || o_done_now !== 1'b1) begin
            failures++; $display("FAIL foreign_result data=%h done=%b exp %h/1", o_lbuf, o_done_now, exp_word(a));
        end
        model_lbuf = exp_word(a);
    endtask

    task automatic test_both_requests();
        logic [63:0] a_ld, a_st, d;
        int bl, bs;
        do_reset();
        rand_line();
        a_ld = rnd64(); a_st = rnd64(); d = rnd64();
        bl = ld_pulses; bs = st_pulses;
        ld_req = 1'b1; st_req = 1'b1; req_addr = a_ld; st_data = rnd64();
        bus_txn(0, 0, -1, 1, -1, a_st, d);
        checks++;
        if (o_rd_addr !== exp_base(a_ld) || o_lbuf !== exp_word(a_ld) || o_done_now !== 1'b1) begin
            failures++;
            $display("FAIL both_load_first addr=%h data=%h done=%b exp %h/%h/1", o_rd_addr, o_lbuf, o_done_now, exp_base(a_ld), exp_word(a_ld));
        end
        checks++;
        if (st_pulses - bs != 0) begin failures++; $display("FAIL both_early_store pulses=%0d exp=0", st_pulses - bs); end
        model_lbuf = exp_word(a_ld);
        bus_txn(1, 0, -1, 1, -1, 64'h0, 64'h0);
        #1;
        checks++;
        if (o_rd_addr !== exp_base(a_st) || o_wr_addr !== exp_base(a_st) || o_done_now !== 1'b1 || o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL both_store rd=%h wr=%h done=%b timeout=%b exp %h/%h/1/0", o_rd_addr, o_wr_addr, o_done_now, o_timeout, exp_base(a_st), exp_base(a_st));
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_wr_beats[k] !== exp_wr(a_st, d, k)) begin
                failures++; $display("FAIL both_beat%0d got=%h exp=%h", k, o_wr_beats[k], exp_wr(a_st, d, k));
            end
        end
        checks++;
        if (ld_pulses - bl != 1 || st_pulses - bs != 1 || o_lbuf !== model_lbuf) begin
            failures++;
            $display("FAIL both_pulses ld=%0d st=%0d lbuf=%h exp 1/1/%h", ld_pulses - bl, st_pulses - bs, o_lbuf, model_lbuf);
        end
    endtask

    task automatic test_reset_mid_write();
        int bs;
        do_reset();
        rand_line();
        ld_req = 1'b1; req_addr = rnd64();
        bus_txn(0, 0, -1, 0, -1, 64'h0, 64'h0);
        rand_line();
        line_data[0] = line_data[0] | 64'h1;
        bs = st_pulses;
        st_req = 1'b1; req_addr = rnd64(); st_data = rnd64();
        bus_txn(1, 0, -1, 0, 4, 64'h0, 64'h0);
        checks++;
        if (o_abort_err !== 1'b0 || o_timeout !== 1'b0) begin
            failures++; $display("FAIL abort_outputs err=%b timeout=%b exp 0/0", o_abort_err, o_timeout);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (st_pulses - bs != 0 || busy !== 1'b0 || bus_reqcyc !== 1'b0 || load_buffer !== 64'h0) begin
            failures++;
            $display("FAIL abort_after pulses=%0d busy=%b reqcyc=%b lbuf=%h exp 0/0/0/0", st_pulses - bs, busy, bus_reqcyc, load_buffer);
        end
        model_lbuf = '0;
    endtask

    task automatic test_random();
        logic [63:0] a, d;
        bit st;
        int b;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            rand_line();
            a = rnd64(); d = rnd64(); st = 1'($urandom_range(0, 1));
            b = st ? st_pulses : ld_pulses;
            if (st) st_req = 1'b1; else ld_req = 1'b1;
            req_addr = a; st_data = d;
            bus_txn(st, $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, 2, -1, rnd64(), rnd64());
            #1;
            if (!st) model_lbuf = exp_word(a);
            checks++;
            if (o_timeout !== 1'b0 || o_rd_addr !== exp_base(a) || o_ack_err != 0 || o_stall_err != 0) begin
                failures++;
                $display("FAIL rand%0d_read timeout=%b addr=%h ackerr=%0d stallerr=%0d exp 0/%h/0/0", n, o_timeout, o_rd_addr, o_ack_err, o_stall_err, exp_base(a));
            end
            checks++;
            if (o_done_now !== 1'b1 || o_lbuf !== model_lbuf || ((st ? st_pulses : ld_pulses) - b) != 1) begin
                failures++;
                $display("FAIL rand%0d_done done=%b lbuf=%h pulses=%0d exp 1/%h/1", n, o_done_now, o_lbuf, (st ? st_pulses : ld_pulses) - b, model_lbuf);
            end
            if (st) begin
                checks++;
                if (o_wr_addr !== exp_base(a) || o_wr_tag_err != 0) begin
                    failures++; $display("FAIL rand%0d_wrreq addr=%h tagerr=%0d exp %h/0", n, o_wr_addr, o_wr_tag_err, exp_base(a));
                end
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (o_wr_beats[k] !== exp_wr(a, d, k)) begin
                        failures++; $display("FAIL rand%0d_beat%0d got=%h exp=%h", n, k, o_wr_beats[k], exp_wr(a, d, k));
                    end
                end
            end
            if (o_timeout) do_reset();
        end
    endtask

    initial begin
        reset = 1'b0; ld_req = 1'b0; st_req = 1'b0; req_addr = '0; st_data = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        model_lbuf = '0;
        test_reset();
        test_load_basic();
        test_store_basic();
        test_reqack_stall();
        test_foreign_tag();
        test_both_requests();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
